// File: rtl/fixed_pkg.sv
// Shared fixed-point definitions for the complex divider: default Q format,
// width helpers, FSM state encoding and saturation constants.
package fixed_pkg;

   localparam int QI_D = 4;
   localparam int QF_D = 4;

   function automatic int width_f(input int qi, input int qf);
      return qi + qf;
   endfunction

   // Dividend width: full |num| product magnitude pre-shifted by QF.
   function automatic int dw_f(input int qi, input int qf);
      return 2 * (qi + qf) + qf;
   endfunction

   function automatic int pw_f(input int w);
      return 2 * w + 1;
   endfunction

   localparam int WIDTH_D = width_f(QI_D, QF_D);
   localparam logic [WIDTH_D-1:0] SAT_MAX_D = {1'b0, {(WIDTH_D-1){1'b1}}};
   localparam logic [WIDTH_D-1:0] SAT_MIN_D = {1'b1, {(WIDTH_D-1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PREP   = 3'd1,
      DIV_RE = 3'd2,
      DIV_IM = 3'd3,
      DONE   = 3'd4
   } state_t;

endpackage

// File: rtl/div_unsigned_serial.sv
// Unsigned restoring divider, one quotient bit per clock. The load cycle
// already performs the first iteration, so valid rises DW-1 cycles after load.
module div_unsigned_serial #(
   parameter int DW = 20
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [DW-1:0] dividend,
   input  logic [DW-1:0] divisor,
   output logic [DW-1:0] quotient,
   output logic          valid
);

   localparam int CW = $clog2(DW + 1);

   logic [DW-1:0] rem_r;
   logic [DW-1:0] quo_r;
   logic [CW-1:0] cnt_r;
   logic          run_r;

   logic [DW-1:0] rem_in_s;
   logic [DW-1:0] quo_in_s;
   logic [DW:0]   trial_s;
   logic [DW-1:0] rem_nx_s;
   logic [DW-1:0] quo_nx_s;
   logic          qbit_s;

   // One restoring step; on load it starts from a zero remainder and the new dividend.
   always_comb begin
      rem_in_s = '0;
      quo_in_s = '0;
      rem_nx_s = '0;
      qbit_s   = 1'b0;
      if (load) begin
         rem_in_s = '0;
         quo_in_s = dividend;
      end else begin
         rem_in_s = rem_r;
         quo_in_s = quo_r;
      end
      trial_s = {rem_in_s, quo_in_s[DW-1]};
      if (trial_s >= {1'b0, divisor}) begin
         rem_nx_s = DW'(trial_s - {1'b0, divisor});
         qbit_s   = 1'b1;
      end else begin
         rem_nx_s = trial_s[DW-1:0];
         qbit_s   = 1'b0;
      end
      quo_nx_s = {quo_in_s[DW-2:0], qbit_s};
   end

   // Iteration state: dividend bits shift out of quo_r as quotient bits shift in.
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_r <= '0;
         quo_r <= '0;
         cnt_r <= '0;
         run_r <= 1'b0;
      end else if (load) begin
         rem_r <= rem_nx_s;
         quo_r <= quo_nx_s;
         cnt_r <= CW'(DW - 1);
         run_r <= 1'b1;
      end else if (run_r && (cnt_r != '0)) begin
         rem_r <= rem_nx_s;
         quo_r <= quo_nx_s;
         cnt_r <= cnt_r - CW'(1);
      end else begin
         rem_r <= rem_r;
         quo_r <= quo_r;
         cnt_r <= cnt_r;
      end
   end

   assign quotient = quo_r;
   assign valid    = run_r && (cnt_r == '0);

endmodule

// File: rtl/div_fixed_complex.sv
// Sequential signed QI.QF complex divider y = a / b: forms a*conj(b) and |b|^2,
// then divides real and imaginary parts in turn on one shared serial divider.
module div_fixed_complex
   import fixed_pkg::*;
#(
   parameter  int QI    = QI_D,
   parameter  int QF    = QF_D,
   localparam int WIDTH = width_f(QI, QF)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_Re,
   input  logic [WIDTH-1:0] a_Im,
   input  logic [WIDTH-1:0] b_Re,
   input  logic [WIDTH-1:0] b_Im,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] y_Re,
   output logic [WIDTH-1:0] y_Im,
   output logic             overflow,
   output logic             div_zero
);

   localparam int DW = dw_f(QI, QF);
   localparam int PW = pw_f(WIDTH);
   localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [DW-1:0]    MAG_MAX = DW'((1 << (WIDTH - 1)) - 1);
   localparam logic [DW-1:0]    MAG_MIN = DW'(1 << (WIDTH - 1));

   state_t                  state_r;
   logic signed [WIDTH-1:0] a_re_r, a_im_r, b_re_r, b_im_r;
   logic [WIDTH-1:0]        y_re_hold_r;
   logic                    ovf_re_r;

   logic signed [PW-1:0] num_re_s, num_im_s, den_full_s;
   logic [PW-1:0]        abs_re_s, abs_im_s;
   logic [2*WIDTH-1:0]   den_s;
   logic [DW-1:0]        dividend_s, quotient_s;
   logic                 load_s, valid_s;
   logic [WIDTH:0]       sat_re_s, sat_im_s;

   // Returns {overflow, value}: sign of num applied to a truncated magnitude, then clamped.
   function automatic logic [WIDTH:0] sat_f(input logic neg, input logic [DW-1:0] mag);
      logic [WIDTH-1:0] low;
      low = mag[WIDTH-1:0];
      if (!neg) begin
         if (mag > MAG_MAX) return {1'b1, SAT_MAX};
         else               return {1'b0, low};
      end else begin
         if (mag > MAG_MIN) return {1'b1, SAT_MIN};
         else               return {1'b0, WIDTH'(-low)};
      end
   endfunction

   // Full-precision products from the held operands; they stay valid for the whole operation.
   always_comb begin
      num_re_s   = PW'(a_re_r) * PW'(b_re_r) + PW'(a_im_r) * PW'(b_im_r);
      num_im_s   = PW'(a_im_r) * PW'(b_re_r) - PW'(a_re_r) * PW'(b_im_r);
      den_full_s = PW'(b_re_r) * PW'(b_re_r) + PW'(b_im_r) * PW'(b_im_r);
      den_s      = den_full_s[2*WIDTH-1:0];
      if (num_re_s < 0) abs_re_s = PW'(-num_re_s);
      else              abs_re_s = PW'(num_re_s);
      if (num_im_s < 0) abs_im_s = PW'(-num_im_s);
      else              abs_im_s = PW'(num_im_s);
      if (state_r == PREP) dividend_s = DW'(abs_re_s) << QF;
      else                 dividend_s = DW'(abs_im_s) << QF;
      load_s   = ((state_r == PREP) && (den_s != '0)) || ((state_r == DIV_RE) && valid_s);
      sat_re_s = sat_f(num_re_s < 0, quotient_s);
      sat_im_s = sat_f(num_im_s < 0, quotient_s);
   end

   div_unsigned_serial #(.DW(DW)) u_div (
      .clk      (clk),
      .rst      (rst),
      .load     (load_s),
      .dividend (dividend_s),
      .divisor  (DW'(den_s)),
      .quotient (quotient_s),
      .valid    (valid_s)
   );

   // Control FSM with registered handshake and results; results publish together at DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         y_Re        <= '0;
         y_Im        <= '0;
         overflow    <= 1'b0;
         div_zero    <= 1'b0;
         a_re_r      <= '0;
         a_im_r      <= '0;
         b_re_r      <= '0;
         b_im_r      <= '0;
         y_re_hold_r <= '0;
         ovf_re_r    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_re_r   <= a_Re;
                  a_im_r   <= a_Im;
                  b_re_r   <= b_Re;
                  b_im_r   <= b_Im;
                  busy     <= 1'b1;
                  y_Re     <= '0;
                  y_Im     <= '0;
                  overflow <= 1'b0;
                  div_zero <= 1'b0;
                  state_r  <= PREP;
               end else begin
                  state_r <= IDLE;
               end
            end
            PREP: begin
               if (den_s == '0) begin
                  overflow <= 1'b1;
                  div_zero <= 1'b1;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state_r  <= DONE;
               end else begin
                  state_r <= DIV_RE;
               end
            end
            DIV_RE: begin
               if (valid_s) begin
                  {ovf_re_r, y_re_hold_r} <= sat_re_s;
                  state_r <= DIV_IM;
               end else begin
                  state_r <= DIV_RE;
               end
            end
            DIV_IM: begin
               if (valid_s) begin
                  y_Re     <= y_re_hold_r;
                  y_Im     <= sat_im_s[WIDTH-1:0];
                  overflow <= ovf_re_r | sat_im_s[WIDTH];
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state_r  <= DONE;
               end else begin
                  state_r <= DIV_IM;
               end
            end
            DONE: begin
               done    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_fixed_complex.sv
// Directed bench for div_fixed_complex: hand-computed quotients, latency,
// saturation, divide-by-zero, ignored restart and mid-operation reset.
module tb_div_fixed_complex;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] a_Re = 8'h00, a_Im = 8'h00, b_Re = 8'h00, b_Im = 8'h00;
   logic       busy, done, overflow, div_zero;
   logic [7:0] y_Re, y_Im;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   div_fixed_complex dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a_Re     (a_Re),
      .a_Im     (a_Im),
      .b_Re     (b_Re),
      .b_Im     (b_Im),
      .busy     (busy),
      .done     (done),
      .y_Re     (y_Re),
      .y_Im     (y_Im),
      .overflow (overflow),
      .div_zero (div_zero)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Issues one operation, optionally pokes a second start at cycle inj, then
   // checks latency, busy, clear-on-accept and the delivered result.
   task automatic run_op(input string tag,
                         input logic [7:0] ar, input logic [7:0] ai,
                         input logic [7:0] br, input logic [7:0] bi,
                         input int lat, input logic [7:0] er, input logic [7:0] ei,
                         input logic eo, input logic ez, input int inj);
      int  n;
      bit  got;
      @(negedge clk);
      a_Re = ar; a_Im = ai; b_Re = br; b_Im = bi;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      got = 1'b0;
      while (n < 60 && !got) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            chk({tag, " busy_first"}, 32'(busy), 32'd1);
            chk({tag, " clear_on_accept"}, 32'({y_Re, y_Im, overflow, div_zero}), 32'd0);
         end
         if (n == lat - 1) chk({tag, " busy_last"}, 32'(busy), 32'd1);
         if (inj != 0 && n == inj) begin
            a_Re = 8'h70; a_Im = 8'h70; b_Re = 8'h10; b_Im = 8'h00;
            start = 1'b1;
         end
         if (inj != 0 && n == inj + 1) start = 1'b0;
         if (done) got = 1'b1;
      end
      chk({tag, " latency"}, 32'(n), 32'(lat));
      chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
      chk({tag, " y_Re"}, 32'(y_Re), 32'(er));
      chk({tag, " y_Im"}, 32'(y_Im), 32'(ei));
      chk({tag, " overflow"}, 32'(overflow), 32'(eo));
      chk({tag, " div_zero"}, 32'(div_zero), 32'(ez));
   endtask

   initial begin
      int done_cnt;

      repeat (3) @(negedge clk);
      chk("reset outputs", 32'({busy, done, y_Re, y_Im, overflow, div_zero}), 32'd0);
      rst = 1'b0;

      // (2+i)/(1+i) = 1.5 - 0.5i
      run_op("basic", 8'h20, 8'h10, 8'h10, 8'h10, 42, 8'h18, 8'hF8, 1'b0, 1'b0, 0);
      repeat (3) @(negedge clk);
      chk("hold done", 32'(done), 32'd0);
      chk("hold y_Re", 32'(y_Re), 32'h18);
      chk("hold y_Im", 32'(y_Im), 32'hF8);

      run_op("roundtrip", 8'h5A, 8'h0A, 8'hC8, 8'h0C, 42, 8'hE8, 8'hF8, 1'b0, 1'b0, 0);
      run_op("trunc_pos", 8'h10, 8'h00, 8'h30, 8'h00, 42, 8'h05, 8'h00, 1'b0, 1'b0, 0);
      run_op("trunc_neg", 8'hF0, 8'h00, 8'h30, 8'h00, 42, 8'hFB, 8'h00, 1'b0, 1'b0, 0);
      run_op("sat_pos", 8'h70, 8'h00, 8'h08, 8'h00, 42, 8'h7F, 8'h00, 1'b1, 1'b0, 0);
      run_op("sat_neg", 8'h90, 8'h00, 8'h08, 8'h00, 42, 8'h80, 8'h00, 1'b1, 1'b0, 0);
      run_op("min_legal", 8'hC0, 8'h00, 8'h08, 8'h00, 42, 8'h80, 8'h00, 1'b0, 1'b0, 0);
      run_op("sat_im", 8'h00, 8'h70, 8'h08, 8'h00, 42, 8'h00, 8'h7F, 1'b1, 1'b0, 0);
      run_op("div_zero", 8'h10, 8'h10, 8'h00, 8'h00, 2, 8'h00, 8'h00, 1'b1, 1'b1, 0);
      run_op("restart_ignored", 8'h20, 8'h10, 8'h10, 8'h10, 42, 8'h18, 8'hF8, 1'b0, 1'b0, 5);

      // Abort an operation with reset sampled at start+10.
      @(negedge clk);
      a_Re = 8'h20; a_Im = 8'h10; b_Re = 8'h10; b_Im = 8'h10;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort outputs", 32'({busy, done, y_Re, y_Im, overflow, div_zero}), 32'd0);
      rst = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      chk("abort no_done", 32'(done_cnt), 32'd0);

      run_op("after_reset", 8'h5A, 8'h0A, 8'hC8, 8'h0C, 42, 8'hE8, 8'hF8, 1'b0, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/div_fixed_complex.md
# div_fixed_complex

Sequential signed fixed-point complex divider computing y = a / b in QI.QF format, the inverse operation of `mult_fixed_complex`. It forms a·conj(b) and |b|² with full-precision products, then runs two serial restoring divisions, real then imaginary, on one shared divider. It sits beside the complex multiplier in the convolution/deconvolution datapath and uses a start/busy/done handshake.

## Interface
- QI, 4, integer bits including sign
- QF, 4, fractional bits
- WIDTH, QI+QF, operand/result width (derived, not overridden)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; operands sampled when start=1 in IDLE
- a_Re, a_Im  in  WIDTH  dividend, signed QI.QF
- b_Re, b_Im  in  WIDTH  divisor, signed QI.QF
- busy  out  1  high from the cycle after accept until done
- done  out  1  one-cycle pulse; results valid from this cycle
- y_Re, y_Im  out  WIDTH  quotient, signed QI.QF
- overflow  out  1  either component saturated, or divide-by-zero
- div_zero  out  1  b = 0

## Operation
- States: IDLE, PREP, DIV_RE, DIV_IM, DONE.
- IDLE: start=1 registers the four operands and goes to PREP. A start while not in IDLE is ignored.
- PREP (1 cycle):
  - num_Re = a_Re·b_Re + a_Im·b_Im
  - num_Im = a_Im·b_Re − a_Re·b_Im
  - den = b_Re² + b_Im²
  - All terms are 2·WIDTH+1 bits signed. den is unsigned 2·WIDTH bits.
  - If den = 0, go to DONE with y_Re = y_Im = 0, overflow = 1 and div_zero = 1.
  - Otherwise load the divider with |num_Re| << QF and go to DIV_RE.
- Divider: unsigned restoring division, one quotient bit per cycle, DW = 2·WIDTH+QF iterations (20 at default). The full quotient is computed, so no magnitude is lost.
- DIV_RE runs DW cycles. It then stores the real result, loads |num_Im| << QF and goes to DIV_IM. DIV_IM runs DW cycles, then goes to DONE.
- Sign and saturation per component:
  - The result magnitude is truncated toward zero, then the sign of num is applied.
  - Positive magnitude > 2^(WIDTH−1)−1 saturates to 0111…1.
  - Negative magnitude > 2^(WIDTH−1) saturates to 100…0.
  - Either saturation sets overflow. A magnitude of exactly 2^(WIDTH−1) when negative is legal and does not set overflow.
- DONE (1 cycle): done=1, busy=0, then IDLE.
- Output holding:
  - y_Re, y_Im, overflow and div_zero hold until the next accepted start.
  - On accept they clear to 0.
- Reset, including mid-operation:
  - State returns to IDLE.
  - busy, done, y_Re, y_Im, overflow and div_zero all become 0.
  - No done pulse is produced for the aborted operation.

## Timing
- start is sampled at edge k. busy is high from cycle k+1 through k+2·DW+1. done is high in cycle k+2·DW+2, i.e. 42 cycles at default.
- Divide-by-zero: busy is high only in cycle k+1, and done is high in cycle k+2.
- The earliest next accept is the cycle after done (IDLE), giving a throughput of one operation per 2·DW+3 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- `fixed_pkg` holds:
  - default QI, QF
  - width helpers for WIDTH, DW and the product width
  - the FSM state enum
  - saturation constants for max and min
- Sub-module `div_unsigned_serial`:
  - parameter DW
  - ports: load, dividend, divisor, quotient, valid
  - one shared instance, reused for the real and imaginary components
- The top level holds the FSM, PREP arithmetic, sign restore and saturation.

## Test plan
- a=(0010_0000, 0001_0000), b=(0001_0000, 0001_0000) → y=(0001_1000, 1111_1000), i.e. 1.5−0.5i, overflow=0, done at start+42.
- Round trip of the multiplier case: a=(0101_1010, 0000_1010), b=(1100_1000, 0000_1100) → y=(1110_1000, 1111_1000), overflow=0.
- Truncation toward zero:
  - a=(0001_0000, 0), b=(0011_0000, 0) → y_Re=0000_0101.
  - a_Re=1111_0000 with the same b → y_Re=1111_1011.
- Saturation:
  - a_Re=0111_0000, b_Re=0000_1000 → y_Re=0111_1111, overflow=1.
  - a_Re=1001_0000 → y_Re=1000_0000, overflow=1.
  - a_Re=1100_0000, b_Re=0000_1000 → y_Re=1000_0000, overflow=0.
- Divide-by-zero: b=0, a=(0001_0000, 0001_0000) → y=(0, 0), overflow=1, div_zero=1, done at start+2.
- Handshake and reset:
  - A second start while busy is ignored; the original result is delivered.
  - rst asserted at start+10 → outputs 0, busy=0, and no done within 50 cycles.
  - A new start after reset works normally.
